// File: rtl/eceg_ciphertext_rx.sv
// rtl/eceg_ciphertext_rx.sv - ECEG ciphertext link receiver: frame assembly, checksum check, point-pair handoff
module eceg_ciphertext_rx #(
    parameter int DATAWIDTH   = 16,
    parameter bit CHECKSUM_EN = 1'b1,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] s_data,
    input  logic                 s_sof,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic [DATAWIDTH-1:0] c1x_out,
    output logic [DATAWIDTH-1:0] c1y_out,
    output logic [DATAWIDTH-1:0] c2x_out,
    output logic [DATAWIDTH-1:0] c2y_out,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 err_frame,
    output logic                 err_chk,
    output logic [CNT_W-1:0]     frame_cnt
);

    typedef enum logic [2:0] {IDLE, GET_C1Y, GET_C2X, GET_C2Y, GET_CHK, HOLD} state_t;

    state_t               state_q, state_d;
    logic [DATAWIDTH-1:0] c1x_q, c1x_d, c1y_q, c1y_d, c2x_q, c2x_d, c2y_q, c2y_d;
    logic [DATAWIDTH-1:0] xor_q, xor_d;
    logic                 m_valid_q, m_valid_d;
    logic                 err_frame_q, err_frame_d;
    logic                 err_chk_q, err_chk_d;
    logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
    logic                 xfer;

    assign s_ready = (state_q != HOLD);
    assign xfer    = s_valid && s_ready;

    always_comb begin
        state_d     = state_q;
        c1x_d       = c1x_q;
        c1y_d       = c1y_q;
        c2x_d       = c2x_q;
        c2y_d       = c2y_q;
        xor_d       = xor_q;
        m_valid_d   = m_valid_q;
        frame_cnt_d = frame_cnt_q;
        err_frame_d = 1'b0;
        err_chk_d   = 1'b0;
        if (state_q == HOLD) begin
            if (m_valid_q && m_ready) begin
                m_valid_d   = 1'b0;
                frame_cnt_d = frame_cnt_q + CNT_W'(1);
                state_d     = IDLE;
            end
        end else if (xfer) begin
            // A start-of-frame word always restarts assembly; mid-frame it also flags the abandoned partial frame.
            if (s_sof) begin
                err_frame_d = (state_q != IDLE);
                c1x_d       = s_data;
                xor_d       = s_data;
                state_d     = GET_C1Y;
            end else begin
                case (state_q)
                    IDLE: err_frame_d = 1'b1;
                    GET_C1Y: begin
                        c1y_d   = s_data;
                        xor_d   = xor_q ^ s_data;
                        state_d = GET_C2X;
                    end
                    GET_C2X: begin
                        c2x_d   = s_data;
                        xor_d   = xor_q ^ s_data;
                        state_d = GET_C2Y;
                    end
                    GET_C2Y: begin
                        c2y_d = s_data;
                        xor_d = xor_q ^ s_data;
                        if (CHECKSUM_EN) begin
                            state_d = GET_CHK;
                        end else begin
                            state_d   = HOLD;
                            m_valid_d = 1'b1;
                        end
                    end
                    GET_CHK: begin
                        if (s_data == xor_q) begin
                            state_d   = HOLD;
                            m_valid_d = 1'b1;
                        end else begin
                            err_chk_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c1x_q       <= '0;
            c1y_q       <= '0;
            c2x_q       <= '0;
            c2y_q       <= '0;
            xor_q       <= '0;
            m_valid_q   <= 1'b0;
            err_frame_q <= 1'b0;
            err_chk_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            c1x_q       <= c1x_d;
            c1y_q       <= c1y_d;
            c2x_q       <= c2x_d;
            c2y_q       <= c2y_d;
            xor_q       <= xor_d;
            m_valid_q   <= m_valid_d;
            err_frame_q <= err_frame_d;
            err_chk_q   <= err_chk_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign c1x_out   = c1x_q;
    assign c1y_out   = c1y_q;
    assign c2x_out   = c2x_q;
    assign c2y_out   = c2y_q;
    assign m_valid   = m_valid_q;
    assign err_frame = err_frame_q;
    assign err_chk   = err_chk_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_eceg_ciphertext_rx.sv
// tb/tb_eceg_ciphertext_rx.sv - directed scoreboard bench for eceg_ciphertext_rx
module tb_eceg_ciphertext_rx;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] s_data;
    logic          s_sof;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] c1x_out, c1y_out, c2x_out, c2y_out;
    logic          m_valid;
    logic          m_ready;
    logic          err_frame;
    logic          err_chk;
    logic [1:0]    frame_cnt;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] c;
        logic [DW-1:0] d;
    } frame_t;

    frame_t exp_q[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     cnt_exp     = 0;

    eceg_ciphertext_rx #(.DATAWIDTH(DW), .CHECKSUM_EN(1'b1), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid),
        .s_ready(s_ready), .c1x_out(c1x_out), .c1y_out(c1y_out), .c2x_out(c2x_out),
        .c2y_out(c2y_out), .m_valid(m_valid), .m_ready(m_ready), .err_frame(err_frame),
        .err_chk(err_chk), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic word(input logic [DW-1:0] d, input logic sof);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic gap(input int mx);
        int n;
        n = $urandom_range(mx, 0);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input logic [DW-1:0] c, input logic [DW-1:0] d,
                              input logic [DW-1:0] ck, input int mx, input bit push);
        frame_t f;
        f.a = a; f.b = b; f.c = c; f.d = d;
        if (push) exp_q.push_back(f);
        gap(mx); word(a, 1'b1);
        gap(mx); word(b, 1'b0);
        gap(mx); word(c, 1'b0);
        gap(mx); word(d, 1'b0);
        gap(mx); word(ck, 1'b0);
    endtask

    // Called right after the last word transfers; m_valid must already be up.
    task automatic deliver(input string tag, input int hold);
        frame_t f;
        chk({tag, "_latency_mvalid"}, 32'(m_valid), 32'd1);
        chk({tag, "_no_err_chk"}, 32'(err_chk), 32'd0);
        chk({tag, "_no_err_frame"}, 32'(err_frame), 32'd0);
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() == 0) return;
        f = exp_q.pop_front();
        repeat (hold) begin
            @(negedge clk);
            chk({tag, "_hold_mvalid"}, 32'(m_valid), 32'd1);
            chk({tag, "_hold_sready"}, 32'(s_ready), 32'd0);
            chk({tag, "_hold_c1x"}, 32'(c1x_out), 32'(f.a));
            chk({tag, "_hold_cnt"}, 32'(frame_cnt), 32'(cnt_exp));
        end
        chk({tag, "_c1x"}, 32'(c1x_out), 32'(f.a));
        chk({tag, "_c1y"}, 32'(c1y_out), 32'(f.b));
        chk({tag, "_c2x"}, 32'(c2x_out), 32'(f.c));
        chk({tag, "_c2y"}, 32'(c2y_out), 32'(f.d));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        cnt_exp = (cnt_exp + 1) % 4;
        chk({tag, "_post_mvalid"}, 32'(m_valid), 32'd0);
        chk({tag, "_post_sready"}, 32'(s_ready), 32'd1);
        chk({tag, "_post_cnt"}, 32'(frame_cnt), 32'(cnt_exp));
        chk({tag, "_post_c2y_kept"}, 32'(c2y_out), 32'(f.d));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        cnt_exp = 0;
        chk("rst_c1x", 32'(c1x_out), 32'd0);
        chk("rst_c2y", 32'(c2y_out), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_sready", 32'(s_ready), 32'd1);
        chk("rst_errs", 32'({err_frame, err_chk}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] r[4];
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // 1: good frame, checksum 1^2^3^4 = 4
        send_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd4, 0, 1'b1);
        deliver("t1", 0);

        // 2: bad checksum drops the frame
        send_frame(16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 0, 1'b0);
        chk("t2_err_chk", 32'(err_chk), 32'd1);
        chk("t2_mvalid", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t2_err_chk_pulse", 32'(err_chk), 32'd0);
        chk("t2_mvalid_after", 32'(m_valid), 32'd0);
        chk("t2_cnt", 32'(frame_cnt), 32'(cnt_exp));
        chk("t2_sready", 32'(s_ready), 32'd1);

        // 3: resync on mid-frame sof
        word(16'd1, 1'b1);
        word(16'd2, 1'b0);
        word(16'd7, 1'b1);
        chk("t3_err_frame", 32'(err_frame), 32'd1);
        chk("t3_no_err_chk", 32'(err_chk), 32'd0);
        exp_q.push_back('{a: 16'd7, b: 16'd8, c: 16'd9, d: 16'd10});
        word(16'd8, 1'b0);
        chk("t3_err_frame_pulse", 32'(err_frame), 32'd0);
        word(16'd9, 1'b0);
        word(16'd10, 1'b0);
        word(16'd7 ^ 16'd8 ^ 16'd9 ^ 16'd10, 1'b0);
        deliver("t3", 0);

        // 4: backpressure for 5 cycles
        send_frame(16'h11, 16'h22, 16'h33, 16'h44, 16'h11 ^ 16'h22 ^ 16'h33 ^ 16'h44, 0, 1'b1);
        deliver("t4", 5);

        // 5: stray word in IDLE, then reset mid-frame
        word(16'h55, 1'b0);
        chk("t5_err_frame", 32'(err_frame), 32'd1);
        chk("t5_mvalid", 32'(m_valid), 32'd0);
        word(16'd1, 1'b1);
        chk("t5_err_frame_clear", 32'(err_frame), 32'd0);
        word(16'd2, 1'b0);
        word(16'd3, 1'b0);
        chk("t5_c1x_before_rst", 32'(c1x_out), 32'd1);
        do_reset();
        send_frame(16'hA1, 16'hB2, 16'hC3, 16'hD4, 16'hA1 ^ 16'hB2 ^ 16'hC3 ^ 16'hD4, 0, 1'b1);
        deliver("t5", 0);

        // 6: wrap of 2-bit counter over 5 frames with random gaps
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) r[j] = DW'($urandom);
            send_frame(r[0], r[1], r[2], r[3], r[0] ^ r[1] ^ r[2] ^ r[3], 3, 1'b1);
            deliver($sformatf("t6_f%0d", k), 0);
        end
        chk("t6_final_cnt", 32'(frame_cnt), 32'd1);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
